// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write bus of program_loader.
// The master drives the byte stream; the slave (the loader) drives the write bus.
interface program_loader_if #(
  parameter int INS_SIZE  = 32,
  parameter int COUNTSIZE = 8
);
  logic [7:0]           inData;
  logic                 inValid;
  logic                 inReady;
  logic                 wrEnable;
  logic [COUNTSIZE-1:0] wrAddress;
  logic [INS_SIZE-1:0]  wrData;

  modport master (
    output inData, inValid,
    input  inReady, wrEnable, wrAddress, wrData
  );

  modport slave (
    input  inData, inValid,
    output inReady, wrEnable, wrAddress, wrData
  );
endinterface

// File: rtl/program_loader.sv
// Streams a program into instruction memory: header byte (word count, 0 = full depth),
// then 4 little-endian bytes per word. Optional trailing XOR checksum: PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int INS_SIZE   = 32,
  parameter int COUNTSIZE  = 8,
  parameter int INS_LENGTH = 256
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  program_loader_if.slave bus,
  output logic            loadDone,
  output logic            loadError,
  output logic            cpuHold
);

  localparam int CW = COUNTSIZE + 1;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    ASSEMBLE,
    WRITE,
    CHECK,
    DONE
  } stateType;

  stateType             state;
  stateType             nextState;
  logic [COUNTSIZE-1:0] wordCount;
  logic [COUNTSIZE-1:0] wordIndex;
  logic [1:0]           byteIndex;
  logic [INS_SIZE-1:0]  wordReg;
  logic [CW-1:0]        wordsTotal;
  logic                 lastWord;
  logic                 transfer;

  // A header of zero stands for a full-depth load.
  assign wordsTotal = (wordCount == '0) ? CW'(INS_LENGTH) : {1'b0, wordCount};
  assign lastWord   = ({1'b0, wordIndex} == (wordsTotal - CW'(1)));
  assign transfer   = bus.inValid & bus.inReady;

  assign bus.wrAddress = wordIndex;
  assign bus.wrData    = wordReg;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves
    // one unassigned and no latch is inferred.
    nextState    = state;
    bus.inReady  = 1'b0;
    bus.wrEnable = 1'b0;
    loadDone     = 1'b0;
    cpuHold      = 1'b1;
    unique case (state)
      IDLE: begin
        if (start) nextState = HEADER;
      end
      HEADER: begin
        bus.inReady = 1'b1;
        if (bus.inValid) nextState = ASSEMBLE;
      end
      ASSEMBLE: begin
        bus.inReady = 1'b1;
        if (bus.inValid && byteIndex == 2'd3) nextState = WRITE;
      end
      WRITE: begin
        bus.wrEnable = 1'b1;
        if (lastWord) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          nextState = CHECK;
`else
          nextState = DONE;
`endif
        end else begin
          nextState = ASSEMBLE;
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CHECK: begin
        bus.inReady = 1'b1;
        if (bus.inValid) nextState = DONE;
      end
`endif
      DONE: begin
        loadDone = 1'b1;
        cpuHold  = 1'b0;
        if (start) nextState = HEADER;
      end
      default: nextState = IDLE;
    endcase
  end

  // Datapath: counters and the word being assembled. A partial word is
  // dropped on reset because the FSM returns to IDLE and byteIndex restarts.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wordCount <= '0;
      wordIndex <= '0;
      byteIndex <= '0;
      wordReg   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            wordIndex <= '0;
            byteIndex <= '0;
          end
        end
        HEADER: begin
          if (transfer) wordCount <= COUNTSIZE'(bus.inData);
        end
        ASSEMBLE: begin
          if (transfer) begin
            wordReg[{byteIndex, 3'b000} +: 8] <= bus.inData;
            byteIndex                        <= byteIndex + 2'd1;
          end
        end
        WRITE: begin
          wordIndex <= wordIndex + COUNTSIZE'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0] checksum;
  logic       loadErrorReg;

  // Running XOR over payload bytes only; the header is excluded.
  always_ff @(posedge clk) begin
    if (!reset) begin
      checksum     <= '0;
      loadErrorReg <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            checksum     <= '0;
            loadErrorReg <= 1'b0;
          end
        end
        ASSEMBLE: begin
          if (transfer) checksum <= checksum ^ bus.inData;
        end
        CHECK: begin
          if (transfer && bus.inData != checksum) loadErrorReg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign loadError = loadErrorReg;
`else
  assign loadError = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a cycle-by-cycle vector table plus
// streamed loads (full depth, stalls, checksum when PROGRAM_LOADER_CHECKSUM_EN is set).
module tb_program_loader;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  typedef struct {
    logic        rst;
    logic        st;
    logic        vld;
    logic [7:0]  dat;
    logic        eRdy;
    logic        eWr;
    logic [7:0]  eAddr;
    logic [31:0] eData;
    logic        eDone;
    logic        eErr;
    logic        eHold;
    logic        chkBus;
  } vecType;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wrType;

  logic clk;
  logic reset;
  logic start;
  logic loadDone;
  logic loadError;
  logic cpuHold;

  program_loader_if #(.INS_SIZE(32), .COUNTSIZE(8)) bus ();

  program_loader #(
    .INS_SIZE  (32),
    .COUNTSIZE (8),
    .INS_LENGTH(256)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bus      (bus.slave),
    .loadDone (loadDone),
    .loadError(loadError),
    .cpuHold  (cpuHold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  vecType     vecs[$];
  logic [7:0] txQ[$];
  wrType      expQ[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic addVec(input logic rst, input logic st, input logic vld, input logic [7:0] dat,
                        input logic eRdy, input logic eWr, input logic [7:0] eAddr,
                        input logic [31:0] eData, input logic eDone, input logic eErr,
                        input logic eHold, input logic chkBus);
    vecType v;
    v.rst = rst; v.st = st; v.vld = vld; v.dat = dat;
    v.eRdy = eRdy; v.eWr = eWr; v.eAddr = eAddr; v.eData = eData;
    v.eDone = eDone; v.eErr = eErr; v.eHold = eHold; v.chkBus = chkBus;
    vecs.push_back(v);
  endtask

  // Issues start, then feeds txQ (with `gap` idle cycles after each accepted byte)
  // until loadDone, checking every write against expQ.
  task automatic streamLoad(input string name, input int gap, input int expWrites,
                            input int expCycles, input logic expErr);
    int   cycles  = 0;
    int   writes  = 0;
    int   waitCnt = 0;
    logic rdy;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cycles < 5000) begin
      if (waitCnt == 0 && txQ.size() > 0) begin
        bus.inValid = 1'b1;
        bus.inData  = txQ[0];
      end else begin
        bus.inValid = 1'b0;
      end
      rdy = bus.inReady;
      @(posedge clk); #1;
      cycles++;
      if (waitCnt > 0) waitCnt--;
      else if (rdy && bus.inValid) begin
        void'(txQ.pop_front());
        waitCnt = gap;
      end
      if (bus.wrEnable) begin
        writes++;
        if (expQ.size() > 0) begin
          check($sformatf("%s wrAddress w%0d", name, writes - 1), 32'(bus.wrAddress), 32'(expQ[0].addr));
          check($sformatf("%s wrData w%0d", name, writes - 1), bus.wrData, expQ[0].data);
          void'(expQ.pop_front());
        end else begin
          check($sformatf("%s unexpected write", name), 32'(writes), 32'(expWrites));
        end
      end
      if (loadDone) break;
    end
    bus.inValid = 1'b0;
    check($sformatf("%s loadDone", name), 32'(loadDone), 32'd1);
    check($sformatf("%s cpuHold", name), 32'(cpuHold), 32'd0);
    check($sformatf("%s loadError", name), 32'(loadError), 32'(expErr));
    check($sformatf("%s write count", name), 32'(writes), 32'(expWrites));
    check($sformatf("%s bytes left", name), 32'(txQ.size()), 32'd0);
    if (expCycles > 0)
      check($sformatf("%s cycles", name), 32'(cycles), 32'(expCycles));
  endtask

  initial begin
    wrType w;
    reset       = 1'b0;
    start       = 1'b0;
    bus.inValid = 1'b0;
    bus.inData  = 8'h00;

    // Table: inputs applied before an edge, outputs compared 1 time unit after it.
    //     rst st vld dat   | rdy wr addr  data          done err hold chkBus
    addVec(0, 0, 0, 8'h00,   0, 0, 8'h00, 32'h00000000, 0, 0, 1, 1);  // reset -> IDLE
    addVec(1, 1, 0, 8'h00,   1, 0, 8'h00, 32'h0,        0, 0, 1, 0);  // HEADER
    addVec(1, 0, 1, 8'h02,   1, 0, 8'h00, 32'h0,        0, 0, 1, 0);  // header 2 words
    addVec(1, 0, 1, 8'h11,   1, 0, 8'h00, 32'h0,        0, 0, 1, 0);
    addVec(1, 1, 1, 8'h22,   1, 0, 8'h00, 32'h0,        0, 0, 1, 0);  // start ignored
    addVec(1, 0, 1, 8'h33,   1, 0, 8'h00, 32'h0,        0, 0, 1, 0);
    addVec(1, 0, 1, 8'h44,   0, 1, 8'h00, 32'h44332211, 0, 0, 1, 1);  // WRITE word 0
    addVec(1, 0, 1, 8'h55,   1, 0, 8'h00, 32'h0,        0, 0, 1, 0);  // held, not taken
    addVec(1, 0, 1, 8'h55,   1, 0, 8'h00, 32'h0,        0, 0, 1, 0);
    addVec(1, 0, 1, 8'h66,   1, 0, 8'h00, 32'h0,        0, 0, 1, 0);
    addVec(1, 0, 1, 8'h77,   1, 0, 8'h00, 32'h0,        0, 0, 1, 0);
    addVec(1, 0, 1, 8'h88,   0, 1, 8'h01, 32'h88776655, 0, 0, 1, 1);  // WRITE word 1
    if (CS != 0) begin
      addVec(1, 0, 1, 8'h88, 1, 0, 8'h00, 32'h0,        0, 0, 1, 0);  // CHECK
      addVec(1, 0, 1, 8'h88, 0, 0, 8'h00, 32'h0,        1, 0, 0, 0);  // good sum -> DONE
    end else begin
      addVec(1, 0, 0, 8'h00, 0, 0, 8'h00, 32'h0,        1, 0, 0, 0);  // DONE
    end
    addVec(1, 0, 0, 8'h00,   0, 0, 8'h00, 32'h0,        1, 0, 0, 0);  // DONE holds
    addVec(1, 1, 0, 8'h00,   1, 0, 8'h00, 32'h0,        0, 0, 1, 0);  // restart
    addVec(1, 0, 1, 8'h02,   1, 0, 8'h00, 32'h0,        0, 0, 1, 0);
    addVec(1, 0, 1, 8'hA1,   1, 0, 8'h00, 32'h0,        0, 0, 1, 0);
    addVec(1, 0, 1, 8'hA2,   1, 0, 8'h00, 32'h0,        0, 0, 1, 0);
    addVec(1, 0, 1, 8'hA3,   1, 0, 8'h00, 32'h0,        0, 0, 1, 0);
    addVec(1, 0, 1, 8'hA4,   0, 1, 8'h00, 32'hA4A3A2A1, 0, 0, 1, 1);  // index cleared by start
    addVec(1, 0, 1, 8'hB1,   1, 0, 8'h00, 32'h0,        0, 0, 1, 0);
    addVec(1, 0, 1, 8'hB1,   1, 0, 8'h00, 32'h0,        0, 0, 1, 0);
    addVec(1, 0, 1, 8'hB2,   1, 0, 8'h00, 32'h0,        0, 0, 1, 0);
    addVec(0, 0, 1, 8'hB3,   0, 0, 8'h00, 32'h00000000, 0, 0, 1, 1);  // reset mid-word
    addVec(1, 0, 0, 8'h00,   0, 0, 8'h00, 32'h0,        0, 0, 1, 0);  // IDLE waits
    addVec(1, 1, 0, 8'h00,   1, 0, 8'h00, 32'h0,        0, 0, 1, 0);
    addVec(1, 0, 1, 8'h01,   1, 0, 8'h00, 32'h0,        0, 0, 1, 0);
    addVec(1, 0, 1, 8'hC1,   1, 0, 8'h00, 32'h0,        0, 0, 1, 0);
    addVec(1, 0, 1, 8'hC2,   1, 0, 8'h00, 32'h0,        0, 0, 1, 0);
    addVec(1, 0, 1, 8'hC3,   1, 0, 8'h00, 32'h0,        0, 0, 1, 0);
    addVec(1, 0, 1, 8'hC4,   0, 1, 8'h00, 32'hC4C3C2C1, 0, 0, 1, 1);  // first write at 0x00
    if (CS != 0) begin
      addVec(1, 0, 1, 8'h05, 1, 0, 8'h00, 32'h0,        0, 0, 1, 0);  // CHECK
      addVec(1, 0, 1, 8'h05, 0, 0, 8'h00, 32'h0,        1, 1, 0, 0);  // sum is 04 -> error
    end else begin
      addVec(1, 0, 0, 8'h00, 0, 0, 8'h00, 32'h0,        1, 0, 0, 0);
    end
    addVec(1, 1, 0, 8'h00,   1, 0, 8'h00, 32'h0,        0, 0, 1, 0);  // start clears error
    addVec(0, 0, 0, 8'h00,   0, 0, 8'h00, 32'h00000000, 0, 0, 1, 1);  // reset mid-load

    foreach (vecs[i]) begin
      reset       = vecs[i].rst;
      start       = vecs[i].st;
      bus.inValid = vecs[i].vld;
      bus.inData  = vecs[i].dat;
      @(posedge clk); #1;
      check($sformatf("vec%0d inReady", i), 32'(bus.inReady), 32'(vecs[i].eRdy));
      check($sformatf("vec%0d wrEnable", i), 32'(bus.wrEnable), 32'(vecs[i].eWr));
      check($sformatf("vec%0d loadDone", i), 32'(loadDone), 32'(vecs[i].eDone));
      check($sformatf("vec%0d loadError", i), 32'(loadError), 32'(vecs[i].eErr));
      check($sformatf("vec%0d cpuHold", i), 32'(cpuHold), 32'(vecs[i].eHold));
      if (vecs[i].chkBus) begin
        check($sformatf("vec%0d wrAddress", i), 32'(bus.wrAddress), 32'(vecs[i].eAddr));
        check($sformatf("vec%0d wrData", i), bus.wrData, vecs[i].eData);
      end
    end
    reset       = 1'b1;
    start       = 1'b0;
    bus.inValid = 1'b0;

    // Full depth: header 0x00, bytes 0..1023 (mod 256), XOR of all is 0x00.
    txQ.delete(); expQ.delete();
    txQ.push_back(8'h00);
    for (int j = 0; j < 1024; j++) txQ.push_back(8'(j));
    if (CS != 0) txQ.push_back(8'h00);
    for (int k = 0; k < 256; k++) begin
      w.addr = 8'(k);
      w.data = {8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1), 8'(4 * k)};
      expQ.push_back(w);
    end
    streamLoad("full", 0, 256, 1 + 5 * 256 + CS, 1'b0);

    // Stalled basic load: three idle cycles after every accepted byte.
    txQ.delete(); expQ.delete();
    txQ = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    if (CS != 0) txQ.push_back(8'h88);
    w.addr = 8'h00; w.data = 32'h44332211; expQ.push_back(w);
    w.addr = 8'h01; w.data = 32'h88776655; expQ.push_back(w);
    streamLoad("stall", 3, 2, 0, 1'b0);

    if (CS != 0) begin
      txQ.delete(); expQ.delete();
      txQ = '{8'h01, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};
      w.addr = 8'h00; w.data = 32'h08040201; expQ.push_back(w);
      streamLoad("csum good", 0, 1, 1 + 5 + 1, 1'b0);

      txQ.delete(); expQ.delete();
      txQ = '{8'h01, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0E};
      w.addr = 8'h00; w.data = 32'h08040201; expQ.push_back(w);
      streamLoad("csum bad", 0, 1, 1 + 5 + 1, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
